// File: rtl/apb_cmd_master.sv
// Command-buffer driven APB requester: pops {write,addr,wdata,strb}, runs one transfer, pushes {timeout,pslverr,rdata}.
// Optional ACCESS watchdog enabled by defining APB_CMD_MASTER_TIMEOUT_EN.
module apb_cmd_master #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                                            clk,
    input  logic                                            reset_n,
    input  logic [ADDR_WIDTH+DATA_WIDTH+DATA_WIDTH/8:0]     cmd_dout,
    input  logic                                            cmd_empty,
    output logic                                            cmd_rd_en,
    output logic [DATA_WIDTH+1:0]                           rsp_din,
    output logic                                            rsp_din_valid,
    input  logic                                            rsp_full,
    output logic                                            psel,
    output logic                                            penable,
    output logic                                            pwrite,
    output logic [ADDR_WIDTH-1:0]                           paddr,
    output logic [DATA_WIDTH-1:0]                           pwdata,
    output logic [DATA_WIDTH/8-1:0]                         pstrb,
    input  logic [DATA_WIDTH-1:0]                           prdata,
    input  logic                                            pready,
    input  logic                                            pslverr,
    output logic                                            busy
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned CMD_WIDTH  = 1 + ADDR_WIDTH + DATA_WIDTH + STRB_WIDTH;

    if (DATA_WIDTH % 8 != 0 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
        $error("apb_cmd_master: illegal DATA_WIDTH or TIMEOUT_CYCLES");
    end

    typedef enum logic [1:0] {IDLE, FETCH, SETUP, ACCESS} state_t;

    state_t                  state_q;
    logic                    psel_q, penable_q, pwrite_q, rsp_valid_q;
    logic [ADDR_WIDTH-1:0]   paddr_q;
    logic [DATA_WIDTH-1:0]   pwdata_q;
    logic [STRB_WIDTH-1:0]   pstrb_q;
    logic [DATA_WIDTH+1:0]   rsp_din_q;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
    logic [15:0]             wdog_q;
`endif

    logic                    cmd_write;
    logic [ADDR_WIDTH-1:0]   cmd_addr;
    logic [DATA_WIDTH-1:0]   cmd_wdata;
    logic [STRB_WIDTH-1:0]   cmd_strb;

    assign cmd_write = cmd_dout[CMD_WIDTH-1];
    assign cmd_addr  = cmd_dout[CMD_WIDTH-2 -: ADDR_WIDTH];
    assign cmd_wdata = cmd_dout[STRB_WIDTH +: DATA_WIDTH];
    assign cmd_strb  = cmd_dout[STRB_WIDTH-1:0];

    // A pending push blocks the pop, so a freshly pushed response is always seen in rsp_full first.
    assign cmd_rd_en = reset_n & (state_q == IDLE) & ~cmd_empty & ~rsp_full & ~rsp_valid_q;
    assign busy      = reset_n & (state_q != IDLE);

    assign psel          = psel_q;
    assign penable       = penable_q;
    assign pwrite        = pwrite_q;
    assign paddr         = paddr_q;
    assign pwdata        = pwdata_q;
    assign pstrb         = pstrb_q;
    assign rsp_din       = rsp_din_q;
    assign rsp_din_valid = rsp_valid_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            rsp_din_q   <= '0;
            rsp_valid_q <= 1'b0;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
            wdog_q      <= '0;
`endif
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_rd_en) state_q <= FETCH;
                end
                FETCH: begin
                    pwrite_q  <= cmd_write;
                    paddr_q   <= cmd_addr;
                    pwdata_q  <= cmd_write ? cmd_wdata : '0;
                    pstrb_q   <= cmd_write ? cmd_strb  : '0;
                    psel_q    <= 1'b1;
                    penable_q <= 1'b0;
                    state_q   <= SETUP;
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ACCESS;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
                    wdog_q    <= '0;
`endif
                end
                ACCESS: begin
                    if (pready) begin
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_din_q   <= {1'b0, pslverr, (pwrite_q ? {DATA_WIDTH{1'b0}} : prdata)};
                        rsp_valid_q <= 1'b1;
                        state_q     <= IDLE;
                    end
`ifdef APB_CMD_MASTER_TIMEOUT_EN
                    else if (wdog_q == 16'(TIMEOUT_CYCLES - 1)) begin
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_din_q   <= {2'b10, {DATA_WIDTH{1'b0}}};
                        rsp_valid_q <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        wdog_q <= wdog_q + 16'd1;
                    end
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/apb_cmd_master.md
APB_CMD_MASTER -- requirements
Module: apb_cmd_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, APB address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, APB data width; multiple of 8.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, access watchdog limit; legal range 1..65535.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port cmd_dout  input  1+ADDR_WIDTH+DATA_WIDTH+DATA_WIDTH/8  command word from the command buffer, packed {write, addr, wdata, strb}, MSB first.
REQ-007 SHALL have port cmd_empty  input  1  command buffer empty.
REQ-008 SHALL have port cmd_rd_en  output  1  command buffer pop.
REQ-009 SHALL have port rsp_din  output  DATA_WIDTH+2  response word {timeout, pslverr, rdata}.
REQ-010 SHALL have port rsp_din_valid  output  1  response buffer push.
REQ-011 SHALL have port rsp_full  input  1  response buffer full.
REQ-012 SHALL have ports psel, penable, pwrite  output  1 each; paddr  output  ADDR_WIDTH; pwdata  output  DATA_WIDTH; pstrb  output  DATA_WIDTH/8: APB requester signals.
REQ-013 SHALL have ports prdata  input  DATA_WIDTH; pready, pslverr  input  1 each: APB completer signals.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL implement states IDLE, FETCH, SETUP, ACCESS.
REQ-016 SHALL drive cmd_rd_en combinationally as (state==IDLE) & !cmd_empty & !rsp_full & !rsp_din_valid; IDLE->FETCH on the same edge.
REQ-017 SHALL treat cmd_dout as valid only in FETCH (buffer read latency one cycle), registering pwrite, paddr, pwdata, pstrb and setting psel=1, penable=0 on the FETCH->SETUP edge.
REQ-018 SHALL force pwdata=0 and pstrb=0 when the command write bit is 0.
REQ-019 SHALL go SETUP->ACCESS unconditionally, setting penable=1; paddr, pwrite, pwdata, pstrb held constant from SETUP until exit from ACCESS.
REQ-020 SHALL remain in ACCESS while pready=0; on pready=1, the next edge clears psel and penable, loads rsp_din={0, pslverr, pwrite ? 0 : prdata}, pulses rsp_din_valid for exactly one cycle, and returns to IDLE.
REQ-021 SHALL push exactly one response per fetched command, in command order, for both reads and writes.
REQ-022 SHALL never push while rsp_full=1; the no-push-pending condition in REQ-016 guarantees this for any response buffer depth >= 1, since this block is that buffer's sole writer.
REQ-023 SHALL have a minimum cost of 5 cycles per transfer back-to-back with pready=1 in the first ACCESS cycle (IDLE blocked one cycle by rsp_din_valid).
REQ-024 SHALL ignore prdata, pslverr and pready outside ACCESS.

Reset
REQ-025 SHALL, on a clk edge with reset_n=0, enter IDLE and clear psel, penable, pwrite, paddr, pwdata, pstrb, rsp_din, rsp_din_valid and the watchdog counter; cmd_rd_en=0 and busy=0 while reset_n=0.
REQ-026 SHALL, on reset in FETCH, SETUP or ACCESS, abandon the command with no response push; the popped command is lost.

Configuration
REQ-027 SHALL, with macro APB_CMD_MASTER_TIMEOUT_EN defined, include a 16-bit watchdog counter that is cleared on SETUP->ACCESS and increments on each ACCESS cycle with pready=0.
REQ-028 SHALL, with the macro defined, terminate the transfer on the edge where pready=0 and the counter equals TIMEOUT_CYCLES-1: clear psel and penable, push rsp_din={1, 0, 0}, and return to IDLE.
REQ-029 SHALL, without the macro, contain no counter, wait in ACCESS indefinitely, and hold rsp_din MSB at 0.

Verification
REQ-030 SHALL cover a single write: cmd {1, 0x100, 0xDEADBEEF, 0xF}, pready=1 immediately -> psel for 2 cycles, penable for 1 cycle, paddr=0x100, pwdata=0xDEADBEEF, one push rsp_din={0,0,0}.
REQ-031 SHALL cover a read with wait states: cmd {0, 0x200, 0, 0}, pready low 3 cycles then high with prdata=0x12345678, pslverr=1 -> ACCESS lasts 4 cycles, pwdata=0, one push {0,1,0x12345678}.
REQ-032 SHALL cover back-to-back traffic: 4 queued commands, pready=1 -> 4 responses in order, psel rising edges exactly 5 cycles apart.
REQ-033 SHALL cover backpressure: rsp_full=1 with cmd_empty=0 -> cmd_rd_en stays 0 and busy=0; rsp_full falls -> cmd_rd_en pulses in that same cycle.
REQ-034 SHALL cover the watchdog: with APB_CMD_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=8, pready held 0 -> exit after 8 ACCESS cycles with push {1,0,0}; without the macro, still in ACCESS after 100 cycles.
REQ-035 SHALL cover reset mid-transfer: reset_n low for one edge in ACCESS -> psel=penable=0 after that edge, no push, state IDLE.
